// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: shared next-PC select encodings, reset PC and nop constant
package fetch_pc_unit_pkg;
  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: decode/hazard control into the fetch unit, fetch/F-D state out
interface fetch_pc_unit_if;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        D_br_taken;
  logic [15:0] D_imm16;
  logic [25:0] D_instr_index;
  logic [31:0] D_rs_val;
  logic [31:0] F_Instr;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic        D_valid;
  logic [31:0] fetch_cnt;
  logic        D_exc_adel;
  modport master (
    output stall, npc_sel, D_br_taken, D_imm16, D_instr_index, D_rs_val, F_Instr,
    input  F_PC, D_PC, D_Instr, D_valid, fetch_cnt, D_exc_adel
  );
  modport slave (
    input  stall, npc_sel, D_br_taken, D_imm16, D_instr_index, D_rs_val, F_Instr,
    output F_PC, D_PC, D_Instr, D_valid, fetch_cnt, D_exc_adel
  );
endinterface

// File: rtl/fetch_pc_unit_npc_calc.sv
// fetch_pc_unit_npc_calc: combinational next-PC mux (seq / branch / j / jr), mod 2^32
module fetch_pc_unit_npc_calc
  import fetch_pc_unit_pkg::*;
(
  input  logic [31:0] f_pc_i,
  input  logic [31:0] d_pc_i,
  input  npc_sel_e    sel_i,
  input  logic        br_taken_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] instr_index_i,
  input  logic [31:0] rs_val_i,
  output logic [31:0] npc_o
);
  logic [31:0] seq, pc4;
  // Select target; branch and jump are relative to the D instruction's PC+4
  always_comb begin
    seq = f_pc_i + 32'd4;
    pc4 = d_pc_i + 32'd4;
    npc_o = sel_i == NPC_BR ? (br_taken_i ? pc4 + {{14{imm16_i[15]}}, imm16_i, 2'b00} : seq) :
            sel_i == NPC_J  ? {pc4[31:28], instr_index_i, 2'b00} :
            sel_i == NPC_JR ? rs_val_i : seq;
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: F-stage PC, F/D register and fetch counter; FETCH_ADDR_CHECK_EN enables fetch address-error flagging
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IM_WORDS = 1024
) (
  input logic            clk,
  input logic            reset_n,
  fetch_pc_unit_if.slave bus
);
  logic [31:0] f_pc_q, f_pc_d, d_pc_q, d_instr_q, d_instr_d, cnt_q, cnt_d, npc;
  logic        d_valid_q, adel_q, adel;
  npc_sel_e    sel;
`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [31:0] PC_END = RESET_PC + 32'(4 * IM_WORDS);
  assign adel = (|f_pc_q[1:0]) || f_pc_q < RESET_PC || f_pc_q >= PC_END;
`else
  assign adel = 1'b0;
`endif
  assign sel = d_valid_q ? npc_sel_e'(bus.npc_sel) : NPC_SEQ;
  fetch_pc_unit_npc_calc u_npc (
    .f_pc_i        (f_pc_q),
    .d_pc_i        (d_pc_q),
    .sel_i         (sel),
    .br_taken_i    (bus.D_br_taken),
    .imm16_i       (bus.D_imm16),
    .instr_index_i (bus.D_instr_index),
    .rs_val_i      (bus.D_rs_val),
    .npc_o         (npc)
  );
  // Next-state values for an unstalled edge; counter saturates at all-ones
  always_comb begin
    f_pc_d = npc;
    d_instr_d = adel ? NOP : bus.F_Instr;
    cnt_d = &cnt_q ? cnt_q : cnt_q + 32'd1;
  end
  // PC, F/D register and counter; the delay-slot word in F is always latched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_pc_q <= RESET_PC;
      d_pc_q <= '0;
      d_instr_q <= '0;
      d_valid_q <= 1'b0;
      cnt_q <= '0;
      adel_q <= 1'b0;
    end else if (!bus.stall) begin
      f_pc_q <= f_pc_d;
      d_pc_q <= f_pc_q;
      d_instr_q <= d_instr_d;
      d_valid_q <= 1'b1;
      cnt_q <= cnt_d;
      adel_q <= adel;
    end
  end
  assign bus.F_PC = f_pc_q;
  assign bus.D_PC = d_pc_q;
  assign bus.D_Instr = d_instr_q;
  assign bus.D_valid = d_valid_q;
  assign bus.fetch_cnt = cnt_q;
  assign bus.D_exc_adel = adel_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed vector table plus reset and address-check sequences
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int fails = 0;
  fetch_pc_unit_if bus ();
  fetch_pc_unit dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [1:0]  sel;
    logic        br;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
    logic [31:0] instr;
    logic [31:0] f_pc;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic [31:0] cnt;
  } vec_t;
  vec_t v [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [1:0] sel, input logic br, input logic [15:0] imm,
                       input logic [25:0] idx, input logic [31:0] rs, input logic [31:0] instr);
    bus.stall = st;
    bus.npc_sel = sel;
    bus.D_br_taken = br;
    bus.D_imm16 = imm;
    bus.D_instr_index = idx;
    bus.D_rs_val = rs;
    bus.F_Instr = instr;
  endtask

  initial begin
    v[0]  = '{1'b0, 2'b11, 1'b0, 16'h0000, 26'h0,     32'h0000_5000, 32'h3C01_0001, 32'h3004, 32'h3000, 32'h3C01_0001, 32'd1};
    v[1]  = '{1'b0, 2'b00, 1'b0, 16'h0000, 26'h0,     32'h0,         32'h11,        32'h3008, 32'h3004, 32'h11,        32'd2};
    v[2]  = '{1'b0, 2'b00, 1'b0, 16'h0000, 26'h0,     32'h0,         32'h22,        32'h300C, 32'h3008, 32'h22,        32'd3};
    v[3]  = '{1'b0, 2'b01, 1'b1, 16'hFFFE, 26'h0,     32'h0,         32'h33,        32'h3004, 32'h300C, 32'h33,        32'd4};
    v[4]  = '{1'b0, 2'b01, 1'b0, 16'hFFFE, 26'h0,     32'h0,         32'h44,        32'h3008, 32'h3004, 32'h44,        32'd5};
    v[5]  = '{1'b0, 2'b00, 1'b0, 16'h0000, 26'h0,     32'h0,         32'h55,        32'h300C, 32'h3008, 32'h55,        32'd6};
    v[6]  = '{1'b0, 2'b00, 1'b0, 16'h0000, 26'h0,     32'h0,         32'h66,        32'h3010, 32'h300C, 32'h66,        32'd7};
    v[7]  = '{1'b0, 2'b00, 1'b0, 16'h0000, 26'h0,     32'h0,         32'h77,        32'h3014, 32'h3010, 32'h77,        32'd8};
    v[8]  = '{1'b0, 2'b10, 1'b0, 16'h0000, 26'hC10,   32'h0,         32'h88,        32'h3040, 32'h3014, 32'h88,        32'd9};
    v[9]  = '{1'b0, 2'b11, 1'b0, 16'h0000, 26'h0,     32'h0000_3100, 32'h99,        32'h3100, 32'h3040, 32'h99,        32'd10};
    v[10] = '{1'b1, 2'b01, 1'b1, 16'h0010, 26'h0,     32'h0,         32'hAA,        32'h3100, 32'h3040, 32'h99,        32'd10};
    v[11] = '{1'b1, 2'b01, 1'b1, 16'h0010, 26'h0,     32'h0,         32'hAA,        32'h3100, 32'h3040, 32'h99,        32'd10};
    v[12] = '{1'b0, 2'b01, 1'b1, 16'h0010, 26'h0,     32'h0,         32'hAA,        32'h3084, 32'h3100, 32'hAA,        32'd11};
    v[13] = '{1'b0, 2'b00, 1'b0, 16'h0000, 26'h0,     32'h0,         32'hBB,        32'h3088, 32'h3084, 32'hBB,        32'd12};
    drive(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0);
    #12;
    chk("rst_f_pc", bus.F_PC, 32'h3000);
    chk("rst_d_pc", bus.D_PC, 32'h0);
    chk("rst_d_instr", bus.D_Instr, 32'h0);
    chk("rst_d_valid", {31'b0, bus.D_valid}, 32'h0);
    chk("rst_cnt", bus.fetch_cnt, 32'h0);
    chk("rst_adel", {31'b0, bus.D_exc_adel}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(v[i].stall, v[i].sel, v[i].br, v[i].imm, v[i].idx, v[i].rs, v[i].instr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_f_pc", i), bus.F_PC, v[i].f_pc);
      chk($sformatf("v%0d_d_pc", i), bus.D_PC, v[i].d_pc);
      chk($sformatf("v%0d_d_instr", i), bus.D_Instr, v[i].d_instr);
      chk($sformatf("v%0d_cnt", i), bus.fetch_cnt, v[i].cnt);
      chk($sformatf("v%0d_valid", i), {31'b0, bus.D_valid}, 32'h1);
      chk($sformatf("v%0d_adel", i), {31'b0, bus.D_exc_adel}, 32'h0);
    end
    drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3020, 32'hC0);
    @(posedge clk);
    #1;
    chk("jr3020_f_pc", bus.F_PC, 32'h3020);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_f_pc", bus.F_PC, 32'h3000);
    chk("arst_valid", {31'b0, bus.D_valid}, 32'h0);
    chk("arst_cnt", bus.fetch_cnt, 32'h0);
    chk("arst_d_instr", bus.D_Instr, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 32'h01);
    @(posedge clk);
    #1;
    chk("post_rst_f_pc", bus.F_PC, 32'h3004);
    drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3102, 32'h02);
    @(posedge clk);
    #1;
    chk("jr3102_f_pc", bus.F_PC, 32'h3102);
    drive(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 32'hCC);
    @(posedge clk);
    #1;
    chk("mis_f_pc", bus.F_PC, 32'h3106);
    chk("mis_d_pc", bus.D_PC, 32'h3102);
`ifdef FETCH_ADDR_CHECK_EN
    chk("mis_d_instr", bus.D_Instr, 32'h0);
    chk("mis_adel", {31'b0, bus.D_exc_adel}, 32'h1);
`else
    chk("mis_d_instr", bus.D_Instr, 32'hCC);
    chk("mis_adel", {31'b0, bus.D_exc_adel}, 32'h0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
